// File: rtl/cpu_mem_model.sv
// Cycle-accurate memory responder: one outstanding request, programmable wait states, backdoor preload, write-trace FIFO.
// Define MEM_TRACE_READS_EN to also push completed reads into the trace FIFO.
module cpu_mem_model #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 65536,
  parameter int WAIT_STATES = 0,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             req_ready,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  input  logic                             bd_we,
  input  logic [ADDR_WIDTH-1:0]            bd_addr,
  input  logic [DATA_WIDTH-1:0]            bd_wdata,
  output logic                             trace_valid,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]   trace_entry,
  input  logic                             trace_pop,
  output logic                             trace_overflow
);

  localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int TP_W   = $clog2(TRACE_DEPTH);
  localparam int TE_W   = 1 + ADDR_WIDTH + DATA_WIDTH;

`ifdef MEM_TRACE_READS_EN
  localparam logic TRACE_READS = 1'b1;
`else
  localparam logic TRACE_READS = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < 64'(MEM_DEPTH);
  endfunction

  function automatic logic [MIDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[MIDX_W-1:0];
  endfunction

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  c_write;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] rd_val;

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign accept     = req_valid && (state == ST_IDLE);
  assign enter_resp = !reset && ((accept && (WAIT_STATES == 0)) ||
                                 ((state == ST_WAIT) && (cnt == 4'd0)));

  // With zero wait states the commit edge is the accepting edge, so the live request is used.
  assign c_write = (state == ST_IDLE) ? req_write : lat_write;
  assign c_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign c_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
  assign rd_val  = in_range(c_addr) ? mem[mem_idx(c_addr)] : '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          cnt   <= 4'(WAIT_STATES - 1);
        end
        ST_WAIT: if (cnt == 4'd0) state <= ST_RESP;
                 else             cnt   <= cnt - 4'd1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Frontdoor assignment comes last so it overrides a same-edge backdoor write.
  always_ff @(posedge clk) begin
    if (bd_we && in_range(bd_addr)) mem[mem_idx(bd_addr)] <= bd_wdata;
    if (enter_resp && c_write && in_range(c_addr)) mem[mem_idx(c_addr)] <= c_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)           rsp_rdata <= '0;
    else if (enter_resp) rsp_rdata <= c_write ? '0 : rd_val;
  end

  // ---- trace FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [TE_W-1:0] tmem [TRACE_DEPTH];
  logic [TP_W:0]   wr_ptr;
  logic [TP_W:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            push_ok;
  logic            pop_ok;
  logic [TE_W-1:0] push_entry;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[TP_W] != rd_ptr[TP_W]) &&
                      (wr_ptr[TP_W-1:0] == rd_ptr[TP_W-1:0]);
  assign push       = enter_resp && (c_write || TRACE_READS);
  assign pop_ok     = trace_pop && !empty;
  assign push_ok    = push && (!full || pop_ok);
  assign push_entry = {c_write, c_addr, c_write ? c_wdata : rd_val};

  assign trace_valid = !empty;
  assign trace_entry = tmem[rd_ptr[TP_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop_ok) trace_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) tmem[wr_ptr[TP_W-1:0]] <= push_entry;
  end

endmodule

// File: tb/tb_cpu_mem_model.sv
// Directed bench for cpu_mem_model: instance 0 has zero wait states, 32K words and a 4-deep trace;
// instance 1 has three wait states and default depths.
module tb_cpu_mem_model;

  logic        clk = 1'b0;
  logic [1:0]  reset, req_valid, req_write, req_ready, rsp_valid;
  logic [1:0]  bd_we, trace_valid, trace_pop, trace_overflow;
  logic [15:0] req_addr [2];
  logic [15:0] bd_addr [2];
  logic [7:0]  req_wdata [2];
  logic [7:0]  bd_wdata [2];
  logic [7:0]  rsp_rdata [2];
  logic [24:0] trace_entry [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cpu_mem_model #(.WAIT_STATES(0), .MEM_DEPTH(32'h8000), .TRACE_DEPTH(4)) u_a (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .bd_we(bd_we[0]),
    .bd_addr(bd_addr[0]), .bd_wdata(bd_wdata[0]), .trace_valid(trace_valid[0]),
    .trace_entry(trace_entry[0]), .trace_pop(trace_pop[0]), .trace_overflow(trace_overflow[0])
  );

  cpu_mem_model #(.WAIT_STATES(3)) u_b (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .bd_we(bd_we[1]),
    .bd_addr(bd_addr[1]), .bd_wdata(bd_wdata[1]), .trace_valid(trace_valid[1]),
    .trace_entry(trace_entry[1]), .trace_pop(trace_pop[1]), .trace_overflow(trace_overflow[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_txn(input int u, input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input bit bd_en, input logic [7:0] bd_d, input bit pop_en,
                        input int exp_lat, output logic [7:0] rd);
    int lat;
    @(negedge clk);
    check("ready_idle", 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1; req_write[u] = wr; req_addr[u] = a; req_wdata[u] = d;
    if (bd_en) begin
      bd_we[u] = 1'b1; bd_addr[u] = a; bd_wdata[u] = bd_d;
    end
    trace_pop[u] = pop_en;
    @(negedge clk);
    req_valid[u] = 1'b0; req_write[u] = ~wr; req_addr[u] = 16'hFFFF; req_wdata[u] = 8'h00;
    bd_we[u] = 1'b0; trace_pop[u] = 1'b0;
    check("ready_busy", 32'(req_ready[u]), 32'd0);
    lat = 1;
    while (!rsp_valid[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    rd = rsp_rdata[u];
    @(negedge clk);
    check("rsp_pulse_end", 32'(rsp_valid[u]), 32'd0);
    check("ready_back", 32'(req_ready[u]), 32'd1);
  endtask

  task automatic rd_txn(input int u, input logic [15:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] r;
    do_txn(u, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0, (u == 0) ? 1 : 4, r);
    check(tag, 32'(r), 32'(exp));
  endtask

  task automatic wr_txn(input int u, input logic [15:0] a, input logic [7:0] d);
    logic [7:0] r;
    do_txn(u, 1'b1, a, d, 1'b0, 8'h00, 1'b0, (u == 0) ? 1 : 4, r);
    check("wr_rdata_zero", 32'(r), 32'd0);
  endtask

  task automatic bd(input int u, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we[u] = 1'b1; bd_addr[u] = a; bd_wdata[u] = d;
    @(negedge clk);
    bd_we[u] = 1'b0;
  endtask

  task automatic pop_check(input int u, input logic [24:0] exp, input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(trace_valid[u]), 32'd1);
    check(tag, 32'(trace_entry[u]), 32'(exp));
    trace_pop[u] = 1'b1;
    @(negedge clk);
    trace_pop[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    for (int i = 0; i < 20 && trace_valid[u]; i++) begin
      @(negedge clk); trace_pop[u] = 1'b1;
      @(negedge clk); trace_pop[u] = 1'b0;
    end
  endtask

  task automatic pulse_reset(input int u);
    @(negedge clk); reset[u] = 1'b1;
    repeat (2) @(negedge clk);
    reset[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    bit seen;
    reset = 2'b11; req_valid = '0; req_write = '0; bd_we = '0; trace_pop = '0;
    for (int u = 0; u < 2; u++) begin
      req_addr[u] = '0; req_wdata[u] = '0; bd_addr[u] = '0; bd_wdata[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", 32'(req_ready[u]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      check("rst_rdata", 32'(rsp_rdata[u]), 32'd0);
      check("rst_trace_valid", 32'(trace_valid[u]), 32'd0);
      check("rst_overflow", 32'(trace_overflow[u]), 32'd0);
    end
    reset = 2'b00;

    // Zero-wait read of backdoor-loaded data.
    bd(0, 16'h0100, 8'h34);
    rd_txn(0, 16'h0100, 8'h34, "ws0_read");

    // Three wait states: write then read back, trace holds the write.
    wr_txn(1, 16'hC000, 8'hA5);
    rd_txn(1, 16'hC000, 8'hA5, "ws3_read");
    pop_check(1, {1'b1, 16'hC000, 8'hA5}, "ws3_trace");

    // Out-of-range accesses on the 32K instance; 0x1000 is the low-bit alias of 0x9000.
    rd_txn(0, 16'h9000, 8'hFF, "oor_read");
    bd(0, 16'h1000, 8'h5A);
    bd(0, 16'h9000, 8'h66);
    rd_txn(0, 16'h1000, 8'h5A, "oor_bd_ignored");
    drain(0);
    wr_txn(0, 16'h9000, 8'h12);
    pop_check(0, {1'b1, 16'h9000, 8'h12}, "oor_wr_trace");
    rd_txn(0, 16'h1000, 8'h5A, "oor_wr_discard");
    rd_txn(0, 16'h9000, 8'hFF, "oor_read_again");

    // Trace FIFO: empty pop, overflow, then push+pop at full.
    drain(0);
    @(negedge clk); trace_pop[0] = 1'b1;
    @(negedge clk); trace_pop[0] = 1'b0;
    check("empty_pop", 32'(trace_valid[0]), 32'd0);
    for (int i = 0; i < 5; i++) wr_txn(0, 16'h0010 + 16'(i), 8'hB0 + 8'(i));
    check("overflow_set", 32'(trace_overflow[0]), 32'd1);
    for (int i = 0; i < 4; i++) pop_check(0, {1'b1, 16'h0010 + 16'(i), 8'hB0 + 8'(i)}, "ovf_order");
    @(negedge clk);
    check("ovf_drained", 32'(trace_valid[0]), 32'd0);
    pulse_reset(0);
    check("overflow_cleared", 32'(trace_overflow[0]), 32'd0);
    for (int i = 0; i < 4; i++) wr_txn(0, 16'h0020 + 16'(i), 8'hC0 + 8'(i));
    check("full_no_ovf", 32'(trace_overflow[0]), 32'd0);
    do_txn(0, 1'b1, 16'h0024, 8'hC4, 1'b0, 8'h00, 1'b1, 1, r);
    check("pushpop_no_ovf", 32'(trace_overflow[0]), 32'd0);
    for (int i = 1; i < 5; i++) pop_check(0, {1'b1, 16'h0020 + 16'(i), 8'hC0 + 8'(i)}, "pushpop_order");
    @(negedge clk);
    check("pushpop_drained", 32'(trace_valid[0]), 32'd0);

    // Reset during the WAIT phase of a write aborts it.
    bd(1, 16'h0200, 8'h11);
    drain(1);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 16'h0200; req_wdata[1] = 8'h77;
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= rsp_valid[1];
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_trace_empty", 32'(trace_valid[1]), 32'd0);
    rd_txn(1, 16'h0200, 8'h11, "abort_mem_kept");

    // Same-edge frontdoor and backdoor writes: frontdoor wins.
    drain(0);
    do_txn(0, 1'b1, 16'h0300, 8'h22, 1'b1, 8'h33, 1'b0, 1, r);
    pop_check(0, {1'b1, 16'h0300, 8'h22}, "collide_wr_trace");
    rd_txn(0, 16'h0300, 8'h22, "collide_read");
`ifdef MEM_TRACE_READS_EN
    pop_check(0, {1'b0, 16'h0300, 8'h22}, "collide_rd_trace");
`else
    @(negedge clk);
    check("reads_not_traced", 32'(trace_valid[0]), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
